// File: rtl/cache_stats_pkg.sv
// Shared definitions for the cache statistics reader: select codes, table size, FSM states.
// Optional build macro: STATS_READER_SNAPSHOT_EN (freeze counters during a sweep).
package cache_stats_pkg;

  localparam int N_WORDS     = 20;
  localparam int COMM_EN_BIT = 24;

  // 64-bit counters are exposed as LO/HI pairs of 32-bit words
  localparam logic [4:0] HIT_LO       = 5'h00;
  localparam logic [4:0] HIT_HI       = 5'h01;
  localparam logic [4:0] MISS_LO      = 5'h02;
  localparam logic [4:0] MISS_HI      = 5'h03;
  localparam logic [4:0] WRITE_LO     = 5'h04;
  localparam logic [4:0] WRITE_HI     = 5'h05;
  localparam logic [4:0] READ_LO      = 5'h06;
  localparam logic [4:0] READ_HI      = 5'h07;
  localparam logic [4:0] EVIC_LO      = 5'h08;
  localparam logic [4:0] EVIC_HI      = 5'h09;
  localparam logic [4:0] WB_LO        = 5'h0A;
  localparam logic [4:0] WB_HI        = 5'h0B;
  localparam logic [4:0] WALLTIME_LO  = 5'h0C;
  localparam logic [4:0] WALLTIME_HI  = 5'h0D;
  localparam logic [4:0] CFG_STATUS   = 5'h0E;
  localparam logic [4:0] CACHE_ID     = 5'h0F;
  localparam logic [4:0] LRU_EVIC_LO  = 5'h10;
  localparam logic [4:0] LRU_EVIC_HI  = 5'h11;
  localparam logic [4:0] RAND_EVIC_LO = 5'h12;
  localparam logic [4:0] RAND_EVIC_HI = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    PUSH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cache_stats_addr_rom.sv
// Combinational sweep-index to controller select-code table.
module cache_stats_addr_rom
  import cache_stats_pkg::*;
(
  input  logic [4:0] index,
  output logic [4:0] select
);

  // ID word first so the host can tag the sweep before the counters arrive
  always_comb begin
    select = CACHE_ID;
    case (index)
      5'd0:    select = CACHE_ID;
      5'd1:    select = HIT_LO;
      5'd2:    select = HIT_HI;
      5'd3:    select = MISS_LO;
      5'd4:    select = MISS_HI;
      5'd5:    select = WRITE_LO;
      5'd6:    select = WRITE_HI;
      5'd7:    select = READ_LO;
      5'd8:    select = READ_HI;
      5'd9:    select = EVIC_LO;
      5'd10:   select = EVIC_HI;
      5'd11:   select = WB_LO;
      5'd12:   select = WB_HI;
      5'd13:   select = WALLTIME_LO;
      5'd14:   select = WALLTIME_HI;
      5'd15:   select = CFG_STATUS;
      5'd16:   select = LRU_EVIC_LO;
      5'd17:   select = LRU_EVIC_HI;
      5'd18:   select = RAND_EVIC_LO;
      5'd19:   select = RAND_EVIC_HI;
      default: select = CACHE_ID;
    endcase
  end

endmodule

// File: rtl/cache_stats_reader.sv
// Walks the statistics table of one cache's performance controller and streams {addr,data}.
// Build macro STATS_READER_SNAPSHOT_EN: hold count-enable low while a sweep is in progress.
module cache_stats_reader
  import cache_stats_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [31:0] comm_o,
  input  logic [31:0] comm_i,
  output logic [31:0] data_o,
  output logic [4:0]  addr_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int              WAIT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [4:0]      LAST_IDX  = 5'(N_WORDS - 1);

  state_t              state, state_next;
  logic [4:0]          index, index_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [4:0]          rom_sel;
  logic                capture;
  logic                busy_next;
  logic                en_next;
  logic [31:0]         comm_next;

  cache_stats_addr_rom u_rom (
    .index  (index_next),
    .select (rom_sel)
  );

  // Next-state: abort overrides everything, including a start in IDLE
  always_comb begin
    state_next = state;
    index_next = index;
    wait_next  = wait_cnt;
    capture    = 1'b0;
    if (abort_i) begin
      state_next = IDLE;
      index_next = 5'd0;
      wait_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_next = SET;
            index_next = 5'd0;
            wait_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
        SET: begin
          if (wait_cnt == WAIT_LAST) begin
            capture    = 1'b1;
            state_next = PUSH;
            wait_next  = '0;
          end else begin
            wait_next  = wait_cnt + WAIT_W'(1);
          end
        end
        PUSH: begin
          if (!ready_i) begin
            state_next = PUSH;
          end else if (index == LAST_IDX) begin
            state_next = DONE;
          end else begin
            index_next = index + 5'd1;
            state_next = SET;
          end
        end
        DONE: begin
          state_next = IDLE;
          index_next = 5'd0;
        end
        default: begin
          state_next = IDLE;
          index_next = 5'd0;
          wait_next  = '0;
        end
      endcase
    end
  end

  // Config word assembly; the select stays on the bus through the whole read and any stall
  always_comb begin
    busy_next = (state_next == SET) || (state_next == PUSH);
`ifdef STATS_READER_SNAPSHOT_EN
    en_next   = enable_i & ~busy_next;
`else
    en_next   = enable_i;
`endif
    comm_next              = 32'h0000_0000;
    comm_next[COMM_EN_BIT] = en_next;
    if (busy_next) begin
      comm_next[4:0] = rom_sel;
    end else begin
      comm_next[4:0] = 5'h00;
    end
  end

  // State and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= IDLE;
      index    <= 5'd0;
      wait_cnt <= '0;
      comm_o   <= 32'h0000_0000;
      data_o   <= 32'h0000_0000;
      addr_o   <= 5'h00;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_next;
      index    <= index_next;
      wait_cnt <= wait_next;
      comm_o   <= comm_next;
      if (capture) begin
        data_o <= comm_i;
        addr_o <= comm_o[4:0];
      end
      valid_o  <= (state_next == PUSH);
      last_o   <= (state_next == PUSH) && (index_next == LAST_IDX);
      busy_o   <= busy_next;
      done_o   <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_cache_stats_reader.sv
// Self-checking bench for cache_stats_reader: scoreboard of expected sweep words plus directed timing checks.
module tb_cache_stats_reader;

`ifdef STATS_READER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, start_i, abort_i, ready_i;
  logic [31:0] comm_o, data_o;
  logic [31:0] comm_i = 32'h0;
  logic [4:0]  addr_o;
  logic        valid_o, last_o, busy_o, done_o;

  cache_stats_reader #(.READ_LATENCY(2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .start_i(start_i),
    .abort_i(abort_i), .comm_o(comm_o), .comm_i(comm_i), .data_o(data_o),
    .addr_o(addr_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial forever #5 clock_i = ~clock_i;

  typedef struct packed { logic [4:0] addr; logic last; } exp_t;

  logic [4:0] sweep_tbl [20] = '{5'h0F, 5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h10, 5'h11,
                                 5'h12, 5'h13};
  exp_t        exp_q[$];
  logic [4:0]  got_addr[$];
  logic [31:0] got_data[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic en_q = 1'b0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last_hs = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [4:0]  prev_addr = 5'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: one register stage returning the selected code as the word
  always @(posedge clock_i) begin
    comm_i <= {27'h0, comm_o[4:0]};
    cyc    <= cyc + 1;
    en_q   <= reset_i ? 1'b0 : enable_i;
  end

  // Compare process
  always @(negedge clock_i) begin
    if (reset_i) begin
      prev_valid   <= 1'b0;
      prev_ready   <= 1'b0;
      prev_last_hs <= 1'b0;
    end else begin
      exp_t e;
      check("comm_reserved", {6'h0, comm_o[31:25], comm_o[23:5]}, 32'h0);
      check("comm_en", {31'h0, comm_o[24]}, {31'h0, en_q & ~(SNAP & busy_o)});
      if (!busy_o) begin
        check("idle_valid", {31'h0, valid_o}, 32'h0);
        check("idle_sel", {27'h0, comm_o[4:0]}, 32'h0);
      end
      if (valid_o) check("held_sel", {27'h0, comm_o[4:0]}, {27'h0, addr_o});
      if (prev_valid && !prev_ready && valid_o) begin
        check("stall_addr", {27'h0, addr_o}, {27'h0, prev_addr});
        check("stall_data", data_o, prev_data);
      end
      if (done_o) check("done_after_last", {31'h0, prev_last_hs}, 32'h1);
      if (valid_o && ready_i) begin
        got_addr.push_back(addr_o);
        got_data.push_back(data_o);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {27'h0, addr_o}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", {27'h0, addr_o}, {27'h0, e.addr});
          check("sb_data", data_o, {27'h0, e.addr});
          check("sb_last", {31'h0, last_o}, {31'h0, e.last});
        end
      end
      prev_valid   <= valid_o;
      prev_ready   <= ready_i;
      prev_addr    <= addr_o;
      prev_data    <= data_o;
      prev_last_hs <= valid_o & ready_i & last_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic start_sweep(output int c0);
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back('{addr: sweep_tbl[i], last: (i == 19)});
    start_i = 1'b1;
    c0 = cyc;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock_i);
      if (done_o) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done_o within %0d cycles", bound);
    end
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock_i);
    check({tag, "_comm"}, comm_o, 32'h0);
    check({tag, "_data"}, data_o, 32'h0);
    check({tag, "_addr"}, {27'h0, addr_o}, 32'h0);
    check({tag, "_flags"}, {27'h0, valid_o, last_o, busy_o, done_o}, 32'h0);
  endtask

  initial begin
    int c0, at;
    reset_i = 1'b1; enable_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    tick(1);
    reset_i = 1'b0;
    enable_i = 1'b1;
    tick(3);
    check("en_before", {31'h0, comm_o[24]}, 32'h1);

    // 1/2/6: full sweep with ready high
    start_sweep(c0);
    tick(10);
    check("en_during", {31'h0, comm_o[24]}, SNAP ? 32'h0 : 32'h1);
    wait_done(200, at);
    check("t1_done_cycle", at - c0, 32'd61);
    check("t1_words", got_addr.size(), 32'd20);
    check("t1_first_addr", {27'h0, got_addr[0]}, 32'h0F);
    check("t1_id_data", got_data[0], 32'h0000_000F);
    check("t1_word5_addr", {27'h0, got_addr[5]}, 32'h04);
    check("t1_last_addr", {27'h0, got_addr[19]}, 32'h13);
    check("t1_sb_empty", exp_q.size(), 32'd0);
    tick(2);
    check("en_after", {31'h0, comm_o[24]}, 32'h1);

    // 3: 10-cycle stall on word 5
    start_sweep(c0);
    tick(17);
    ready_i = 1'b0;
    tick(5);
    @(negedge clock_i);
    check("t3_stall_sel", {27'h0, comm_o[4:0]}, 32'h04);
    check("t3_stall_addr", {27'h0, addr_o}, 32'h04);
    check("t3_stall_valid", {31'h0, valid_o}, 32'h1);
    tick(5);
    ready_i = 1'b1;
    wait_done(200, at);
    check("t3_done_cycle", at - c0, 32'd71);
    check("t3_words", got_addr.size(), 32'd20);

    // 4: abort while word 7 is presented
    start_sweep(c0);
    tick(23);
    ready_i = 1'b0;
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    ready_i = 1'b1;
    exp_q.delete();
    @(negedge clock_i);
    check("t4_abort_flags", {27'h0, valid_o, last_o, busy_o, done_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      check("t4_no_done", {31'h0, done_o}, 32'h0);
    end
    tick(1);
    start_sweep(c0);
    wait_done(200, at);
    check("t4_restart_first", {27'h0, got_addr[0]}, 32'h0F);
    check("t4_restart_done", at - c0, 32'd61);

    // 5: start pulses while busy are ignored
    start_sweep(c0);
    tick(4);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(20);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    wait_done(200, at);
    check("t5_done_cycle", at - c0, 32'd61);
    tick(10);
    check("t5_words", got_addr.size(), 32'd20);
    check("t5_idle_busy", {31'h0, busy_o}, 32'h0);

    // 5: reset mid-sweep, then abort and start together in IDLE
    start_sweep(c0);
    tick(10);
    reset_i = 1'b1;
    tick(1);
    exp_q.delete();
    check_reset_outputs("t5_midreset");
    tick(1);
    reset_i = 1'b0;
    start_i = 1'b1; abort_i = 1'b1;
    tick(1);
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clock_i);
    check("t5_abort_wins", {31'h0, busy_o}, 32'h0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
